// File: rtl/blitter_pkg.sv
// Shared definitions for the blitter: instruction field layout, decoded
// instruction struct and FSM state encoding.
package blitter_pkg;

    localparam int INSTR_W      = 64;
    localparam int SRC_BASE_LSB = 48;
    localparam int SRC_BASE_W   = 16;
    localparam int DST_X_LSB    = 38;
    localparam int DST_X_W      = 10;
    localparam int DST_Y_LSB    = 29;
    localparam int DST_Y_W      = 9;
    localparam int WIDTH_LSB    = 22;
    localparam int WIDTH_W      = 7;
    localparam int HEIGHT_LSB   = 15;
    localparam int HEIGHT_W     = 7;
    localparam int KEY_EN_BIT   = 0;

    // Screen-position width used for clipping; wide enough that dst + offset never wraps.
    localparam int POS_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_WAIT_CLR
    } blit_state_t;

    typedef struct packed {
        logic [SRC_BASE_W-1:0] src_base;
        logic [DST_X_W-1:0]    dst_x;
        logic [DST_Y_W-1:0]    dst_y;
        logic [WIDTH_W-1:0]    width;
        logic [HEIGHT_W-1:0]   height;
        logic                  key_en;
    } blit_instr_t;

    function automatic blit_instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        blit_instr_t d;
        d.src_base = raw[SRC_BASE_LSB +: SRC_BASE_W];
        d.dst_x    = raw[DST_X_LSB +: DST_X_W];
        d.dst_y    = raw[DST_Y_LSB +: DST_Y_W];
        d.width    = raw[WIDTH_LSB +: WIDTH_W];
        d.height   = raw[HEIGHT_LSB +: HEIGHT_W];
        d.key_en   = raw[KEY_EN_BIT];
        return d;
    endfunction

endpackage

// File: rtl/blitter_addr_gen.sv
// Row/column walker for the blitter: incremental sprite ROM and frame-buffer
// addresses plus clip flags, with no multiplier in the per-pixel path.
module blitter_addr_gen
    import blitter_pkg::*;
#(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int FB_ADDR_W = 17
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  load,
    input  blit_instr_t           load_instr,
    input  blit_instr_t           ins,
    input  logic                  advance,
    output logic [SRC_BASE_W-1:0] src_addr,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic                  clip,
    output logic                  last_pixel
);

    logic [WIDTH_W-1:0]   col;
    logic [HEIGHT_W-1:0]  row;
    logic [POS_W-1:0]     x_pos;
    logic [POS_W-1:0]     y_pos;
    logic [FB_ADDR_W-1:0] row_base;
    logic [FB_ADDR_W-1:0] pix_addr;
    logic [FB_ADDR_W-1:0] load_origin;
    logic                 last_col;
    logic                 last_row;
    logic                 unused_fields;

    // The one multiply happens once per instruction, at accept time.
    assign load_origin = FB_ADDR_W'(load_instr.dst_y) * FB_ADDR_W'(FB_WIDTH)
                       + FB_ADDR_W'(load_instr.dst_x);

    assign last_col   = (col == ins.width - WIDTH_W'(1));
    assign last_row   = (row == ins.height - HEIGHT_W'(1));
    assign last_pixel = last_col && last_row;
    assign clip       = (x_pos >= POS_W'(FB_WIDTH)) || (y_pos >= POS_W'(FB_HEIGHT));
    assign fb_addr    = pix_addr;

    assign unused_fields = ^{load_instr.width, load_instr.height, load_instr.key_en,
                             ins.src_base, ins.dst_y, ins.key_en};

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            col      <= '0;
            row      <= '0;
            x_pos    <= '0;
            y_pos    <= '0;
            row_base <= '0;
            pix_addr <= '0;
            src_addr <= '0;
        end else if (load) begin
            col      <= '0;
            row      <= '0;
            x_pos    <= POS_W'(load_instr.dst_x);
            y_pos    <= POS_W'(load_instr.dst_y);
            row_base <= load_origin;
            pix_addr <= load_origin;
            src_addr <= load_instr.src_base;
        end else if (advance) begin
            // Row-major walk makes the ROM address a plain linear count.
            src_addr <= src_addr + SRC_BASE_W'(1);
            if (last_col) begin
                col      <= '0;
                row      <= row + HEIGHT_W'(1);
                x_pos    <= POS_W'(ins.dst_x);
                y_pos    <= y_pos + POS_W'(1);
                row_base <= row_base + FB_ADDR_W'(FB_WIDTH);
                pix_addr <= row_base + FB_ADDR_W'(FB_WIDTH);
            end else begin
                col      <= col + WIDTH_W'(1);
                x_pos    <= x_pos + POS_W'(1);
                pix_addr <= pix_addr + FB_ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/blitter_engine.sv
// Sprite blitter: copies a width x height block from sprite ROM into the frame
// buffer with clipping; colour-key transparency when BLITTER_TRANSPARENCY_EN is defined.
module blitter_engine
    import blitter_pkg::*;
#(
    parameter int         FB_WIDTH  = 320,
    parameter int         FB_HEIGHT = 240,
    parameter int         FB_ADDR_W = 17,
    parameter logic [7:0] KEY_COLOR = 8'h00
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [63:0]          INSTR,
    input  logic                 INSTR_VALID,
    output logic                 FINISH_FLIP,
    output logic [15:0]          SRC_ADDR,
    input  logic [7:0]           SRC_DATA,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic [7:0]           FB_WDATA,
    output logic                 FB_WE,
    input  logic                 FB_WAIT,
    output logic                 BUSY
);

    blit_state_t          state;
    blit_state_t          next_state;
    blit_instr_t          dec;
    blit_instr_t          cur;
    logic                 load;
    logic                 advance;
    logic                 in_write;
    logic                 skip;
    logic                 transparent;
    logic                 clip;
    logic                 last_pixel;
    logic [15:0]          src_addr;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic                 unused_bits;

    assign dec = decode_instr(INSTR);

`ifdef BLITTER_TRANSPARENCY_EN
    assign transparent = cur.key_en && (SRC_DATA == KEY_COLOR);
    assign unused_bits = ^INSTR[14:1];
`else
    assign transparent = 1'b0;
    assign unused_bits = ^{INSTR[14:1], KEY_COLOR};
`endif

    assign in_write = (state == ST_WRITE);
    assign skip     = clip || transparent;

    blitter_addr_gen #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .FB_ADDR_W (FB_ADDR_W)
    ) u_addr_gen (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .load       (load),
        .load_instr (dec),
        .ins        (cur),
        .advance    (advance),
        .src_addr   (src_addr),
        .fb_addr    (fb_addr),
        .clip       (clip),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_IDLE;
            cur   <= '0;
        end else begin
            state <= next_state;
            if (load) cur <= dec;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (INSTR_VALID) begin
                    load       = 1'b1;
                    next_state = (dec.width == '0 || dec.height == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: next_state = ST_WRITE;
            ST_WRITE: begin
                // Skipped pixels never wait on the frame buffer.
                if (skip || !FB_WAIT) begin
                    advance    = 1'b1;
                    next_state = last_pixel ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: next_state = ST_WAIT_CLR;
            ST_WAIT_CLR: begin
                if (!INSTR_VALID) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign SRC_ADDR    = (state == ST_READ || in_write) ? src_addr : '0;
    assign FB_ADDR     = in_write ? fb_addr : '0;
    assign FB_WDATA    = in_write ? SRC_DATA : '0;
    assign FB_WE       = in_write && !skip;
    assign FINISH_FLIP = (state == ST_DONE);
    assign BUSY        = (state != ST_IDLE);

endmodule
